mem_refill_arbiter: RTL and testbench

- Shares the single line-refill memory port between NrReq cache miss requesters: port 0 is the instruction cache, port 1 is the data cache.
- Sits between the caches' miss interfaces and the memory controller.
- Grants one requester at a time, round-robin, and holds the memory request stable until the line returns.
- Routes the response to the granted requester only, and flags memory stalls with a watchdog.

---
 rtl/cache_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/mem_refill_arbiter.sv | 118 +++++++++++
 tb/tb_mem_refill_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and geometry: refill line shape and the
// refill arbiter's state encoding.
package cache_pkg;

    localparam int LineSize       = 128;
    localparam int NrWordsPerLine = LineSize / 32;
    localparam int ByteOffsetBits = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef logic [LineSize-1:0] line_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo N. Shared by refill and write-back arbitration.
module rr_pick #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            found,
    output logic [IdxW-1:0] idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % N;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one line-refill memory port between cache
// miss requesters; one transaction in flight, response routed to its owner.
module mem_refill_arbiter
    import cache_pkg::*;
#(
    parameter int NrReq          = 2,
    parameter int LineSize       = cache_pkg::LineSize,
    parameter int ByteOffsetBits = cache_pkg::ByteOffsetBits,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NrReq-1:0]         req_i,
    input  logic [NrReq-1:0][31:0]   req_addr_i,
    output logic [NrReq-1:0]         resp_valid_o,
    output logic [LineSize-1:0]      resp_data_o,
    output logic                     mem_read_en_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_read_valid_i,
    input  logic [LineSize-1:0]      mem_read_data_i,
    output logic                     timeout_o,
    output logic                     busy_o,
    output arb_state_e               state_o
);

    localparam int IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int WdW  = $clog2(TimeoutCycles + 1);

    // Handshake: req_i is a level held by the cache until it sees its
    // resp_valid_o pulse; mem_read_en_o/mem_addr_o are held stable from grant
    // until the single-cycle mem_read_valid_i pulse, which is accepted only
    // in BUSY.

    arb_state_e      state, state_n;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] grant_idx;
    logic [WdW-1:0]  wd_cnt;
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] next_ptr;

    rr_pick #(
        .N    (NrReq),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (grant_idx == IdxW'(NrReq - 1)) ? '0 : grant_idx + IdxW'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_found) state_n = BUSY;
            BUSY:    if (mem_read_valid_i) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            mem_read_en_o <= 1'b0;
            mem_addr_o    <= '0;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            state         <= state_n;
            mem_read_en_o <= (state_n == BUSY);
            busy_o        <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx  <= pick_idx;
                        mem_addr_o <= {req_addr_i[pick_idx][31:ByteOffsetBits],
                                       {ByteOffsetBits{1'b0}}};
                    end
                end
                BUSY: begin
                    if (mem_read_valid_i) begin
                        rr_ptr <= next_ptr;
                        wd_cnt <= '0;
                    end else if (wd_cnt != WdW'(TimeoutCycles)) begin
                        // Saturating count; the flag is sticky until reset.
                        wd_cnt <= wd_cnt + WdW'(1);
                        if (wd_cnt == WdW'(TimeoutCycles - 1)) timeout_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester that dropped its miss no longer wants the line: no pulse.
    always_comb begin
        resp_valid_o = '0;
        if (mem_read_valid_i && (state == BUSY) && req_i[grant_idx])
            resp_valid_o[grant_idx] = 1'b1;
    end

    assign resp_data_o = mem_read_data_i;
    assign state_o     = state;

    logic unused_addr_bits;
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NrReq; i++)
            unused_addr_bits = unused_addr_bits ^ (^req_addr_i[i][ByteOffsetBits-1:0]);
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: single miss, simultaneous misses,
// fairness, address stability, dropped requester, watchdog and reset abort.
module tb_mem_refill_arbiter;
    import cache_pkg::*;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        resp_valid;
    logic [127:0]      resp_data;
    logic              mem_en;
    logic [31:0]       mem_addr;
    logic              mem_valid;
    logic [127:0]      mem_data;
    logic              timeout;
    logic              busy;
    arb_state_e        state;

    int n_cmp = 0;
    int n_err = 0;

    mem_refill_arbiter #(
        .NrReq         (2),
        .LineSize      (128),
        .ByteOffsetBits(4),
        .TimeoutCycles (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_addr_i       (req_addr),
        .resp_valid_o     (resp_valid),
        .resp_data_o      (resp_data),
        .mem_read_en_o    (mem_en),
        .mem_addr_o       (mem_addr),
        .mem_read_valid_i (mem_valid),
        .mem_read_data_i  (mem_data),
        .timeout_o        (timeout),
        .busy_o           (busy),
        .state_o          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [127:0] line;
        line      = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        rst       = 1'b1;
        req       = 2'b00;
        req_addr  = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_state", state, IDLE);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_resp", resp_valid, 2'b00);

        // single miss on port 0, memory returns in cycle 5
        req = 2'b01;
        req_addr[0] = 32'h0000_1234;
        tick();
        chk("s_en", mem_en, 1'b1);
        chk("s_addr", mem_addr, 32'h0000_1230);
        chk("s_busy", busy, 1'b1);
        tick(); tick(); tick();
        chk("s_en_wait", mem_en, 1'b1);
        chk("s_resp_early", resp_valid, 2'b00);
        tick();
        mem_valid = 1'b1;
        mem_data  = line;
        #1;
        chk("s_resp", resp_valid, 2'b01);
        chk("s_data", resp_data, line);
        tick();
        mem_valid = 1'b0;
        chk("s_done_state", state, DONE);
        chk("s_done_en", mem_en, 1'b0);
        chk("s_done_busy", busy, 1'b1);
        chk("s_done_resp", resp_valid, 2'b00);
        req = 2'b00;
        tick();
        chk("s_idle_state", state, IDLE);
        chk("s_idle_busy", busy, 1'b0);

        // simultaneous misses from reset: port 0 first, then port 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_addr[0] = 32'h0000_0100;
        req_addr[1] = 32'h0000_2000;
        req = 2'b11;
        tick();
        chk("sim_addr0", mem_addr, 32'h0000_0100);
        tick();
        mem_valid = 1'b1;
        #1;
        chk("sim_resp0", resp_valid, 2'b01);
        tick();
        mem_valid = 1'b0;
        chk("sim_done_en", mem_en, 1'b0);
        req = 2'b10;
        tick();
        chk("sim_idle_en", mem_en, 1'b0);
        chk("sim_idle_state", state, IDLE);
        tick();
        chk("sim_en1", mem_en, 1'b1);
        chk("sim_addr1", mem_addr, 32'h0000_2000);
        mem_valid = 1'b1;
        #1;
        chk("sim_resp1", resp_valid, 2'b10);
        tick();
        mem_valid = 1'b0;
        req = 2'b00;
        tick();

        // fairness: both requesting continuously, six transactions
        req_addr[0] = 32'h0000_A000;
        req_addr[1] = 32'h0000_B000;
        req = 2'b11;
        tick();
        for (int t = 0; t < 6; t++) begin
            chk("fair_addr", mem_addr, (t % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000);
            mem_valid = 1'b1;
            #1;
            chk("fair_resp", resp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            mem_valid = 1'b0;
            tick();
            if (t == 5) req = 2'b01;
            tick();
        end

        // address stability: port 0 in BUSY, its address changes underneath
        chk("stab_state", state, BUSY);
        chk("stab_addr0", mem_addr, 32'h0000_A000);
        req_addr[0] = 32'hFFFF_0000;
        tick();
        chk("stab_addr1", mem_addr, 32'h0000_A000);
        tick();
        chk("stab_addr2", mem_addr, 32'h0000_A000);
        mem_valid = 1'b1;
        #1;
        chk("stab_resp", resp_valid, 2'b01);
        tick();
        mem_valid = 1'b0;
        chk("stab_done_addr", mem_addr, 32'h0000_A000);
        req = 2'b00;
        tick();

        // dropped requester: port 1 granted, then withdraws
        req_addr[0] = 32'h0000_4004;
        req_addr[1] = 32'h0000_3000;
        req = 2'b11;
        tick();
        chk("drop_addr", mem_addr, 32'h0000_3000);
        req = 2'b01;
        tick();
        mem_valid = 1'b1;
        #1;
        chk("drop_resp", resp_valid, 2'b00);
        tick();
        mem_valid = 1'b0;
        chk("drop_done", state, DONE);
        tick();
        tick();
        chk("drop_next_addr", mem_addr, 32'h0000_4000);
        chk("drop_next_en", mem_en, 1'b1);

        // watchdog: response withheld, then reset aborts the transaction
        tick(); tick(); tick(); tick(); tick();
        chk("wd_early", timeout, 1'b0);
        tick(); tick(); tick(); tick();
        chk("wd_set", timeout, 1'b1);
        chk("wd_state", state, BUSY);
        chk("wd_en", mem_en, 1'b1);
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
        chk("abort_state", state, IDLE);
        chk("abort_en", mem_en, 1'b0);
        chk("abort_timeout", timeout, 1'b0);
        chk("abort_busy", busy, 1'b0);
        req = 2'b01;
        mem_valid = 1'b1;
        #1;
        chk("late_resp", resp_valid, 2'b00);
        req = 2'b00;
        tick();
        mem_valid = 1'b0;
        chk("late_state", state, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
